ahb_sram_slave: RTL and testbench

//  Parametrised AHB-Lite SRAM slave replacing the single-cycle RAM model.
//  - Byte-addressed, little-endian storage; depth and wait states set by parameters.
//  - Pipelined address/data phases, HREADYOUT wait-state insertion, two-cycle ERROR

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_slv_byte_array.sv | 43 ++++
 rtl/ahb_sram_slave.sv | 171 +++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

    // Byte lanes touched by a legal transfer size (byte, halfword, word).
    function automatic logic [3:0] sizeLaneMask(input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slv_byte_array.sv
// Byte-wide storage for the AHB SRAM slave: lane-masked write port and a
// combinational little-endian 32-bit read window.
module ahb_slv_byte_array #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [3:0]           wmask_i,
    input  logic [31:0]          wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [31:0]          rdata_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [7:0] mem_q [DEPTH];

    // Clear every byte on reset; otherwise commit the enabled lanes starting at the write address.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (wmask_i[lane]) begin
                    mem_q[waddr_i + ADDR_BITS'(lane)] <= wdata_i[8*lane +: 8];
                end
            end
        end
    end

    // Four consecutive bytes from the read address, lowest address in the low lane.
    always_comb begin
        rdata_o = '0;
        for (int lane = 0; lane < 4; lane++) begin
            rdata_o[8*lane +: 8] = mem_q[raddr_i + ADDR_BITS'(lane)];
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, programmable wait
// states, two-cycle ERROR response and sign/zero-extended sub-word reads.
module ahb_sram_slave #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    input  logic        is_signed,
    output logic [31:0] hrdata,
    output logic        hready_out,
    output logic        hresp
);

    import ahb_pkg::*;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    slv_state_t           state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [1:0]           size_q, size_d;
    logic                 write_q, write_d;
    logic                 signed_q, signed_d;
    logic [3:0]           waitCnt_q, waitCnt_d;

    logic        accept;
    logic        illegal;
    logic        phaseOpen;
    logic        memWe;
    logic [31:0] memRdata;
    logic [31:0] readExt;

    assign accept = hsel && hready_in &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    // Legality of the transfer currently in its address phase.
    always_comb begin
        illegal = 1'b0;
        if (hsize > HSIZE_WORD) begin
            illegal = 1'b1;
        end
        if ((hsize == HSIZE_HALF) && haddr[0]) begin
            illegal = 1'b1;
        end
        if ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
        if (haddr[31:ADDR_BITS] != '0) begin
            illegal = 1'b1;
        end
    end

    // Next-state logic: count down wait states, step through ERROR, and take a new transfer when idle or completing.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        write_d   = write_q;
        signed_d  = signed_q;
        waitCnt_d = waitCnt_q;
        phaseOpen = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phaseOpen = 1'b1;
            end
            ST_DATA: begin
                if (waitCnt_q != 4'd0) begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end else begin
                    phaseOpen = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (phaseOpen && accept) begin
            addr_d    = haddr[ADDR_BITS-1:0];
            size_d    = hsize[1:0];
            write_d   = hwrite;
            signed_d  = is_signed;
            waitCnt_d = WAIT_INIT;
            state_d   = illegal ? ST_ERR1 : ST_DATA;
        end
    end

    // Data-phase register and state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= 2'd0;
            write_q   <= 1'b0;
            signed_q  <= 1'b0;
            waitCnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            write_q   <= write_d;
            signed_q  <= signed_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // A write commits only on the edge that completes its data phase.
    assign memWe = (state_q == ST_DATA) && write_q && (waitCnt_q == 4'd0);

    ahb_slv_byte_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (memWe),
        .waddr_i (addr_q),
        .wmask_i (sizeLaneMask(size_q)),
        .wdata_i (hwdata),
        .raddr_i (addr_q),
        .rdata_o (memRdata)
    );

    // Sub-word reads are zero- or sign-extended; word reads pass straight through.
    always_comb begin
        readExt = memRdata;
        case (size_q)
            2'd0:    readExt = {{24{signed_q & memRdata[7]}}, memRdata[7:0]};
            2'd1:    readExt = {{16{signed_q & memRdata[15]}}, memRdata[15:0]};
            default: readExt = memRdata;
        endcase
    end

    // Bus-facing outputs decoded from the current state.
    always_comb begin
        hready_out = 1'b1;
        hresp      = HRESP_OKAY;
        hrdata     = 32'h0000_0000;
        case (state_q)
            ST_DATA: begin
                hready_out = (waitCnt_q == 4'd0);
                if (!write_q) begin
                    hrdata = readExt;
                end
            end
            ST_ERR1: begin
                hready_out = 1'b0;
                hresp      = HRESP_ERROR;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
            end
            default: begin
                hready_out = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: two slaves (2 and 0 wait states) on one bus, checked
// against a byte-array model of the memory and the AHB response rules.
module tb_ahb_sram_slave;

    localparam int AB    = 8;
    localparam int DEPTH = 1 << AB;
    localparam int WS_A  = 2;
    localparam int WS_B  = 0;

    typedef struct {
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        bit          sgn;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        hselA, hselB, useB;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata;
    logic        hreadyIn, isSigned;
    logic [31:0] hrdataA, hrdataB;
    logic        hreadyA, hreadyB, hrespA, hrespB;

    logic [7:0]  modelMem [2][DEPTH];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign hreadyIn = useB ? hreadyB : hreadyA;

    ahb_sram_slave #(.ADDR_BITS(AB), .WAIT_STATES(WS_A)) dutA (
        .clk(clk), .reset(reset), .hsel(hselA), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready_in(hreadyIn),
        .is_signed(isSigned), .hrdata(hrdataA), .hready_out(hreadyA), .hresp(hrespA)
    );

    ahb_sram_slave #(.ADDR_BITS(AB), .WAIT_STATES(WS_B)) dutB (
        .clk(clk), .reset(reset), .hsel(hselB), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready_in(hreadyIn),
        .is_signed(isSigned), .hrdata(hrdataB), .hready_out(hreadyB), .hresp(hrespB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic xfer_t mk(input bit wr, input logic [2:0] size, input logic [31:0] addr,
                                 input bit sgn, input logic [31:0] wdata);
        xfer_t x;
        x.wr = wr; x.size = size; x.addr = addr; x.sgn = sgn; x.wdata = wdata;
        return x;
    endfunction

    function automatic bit isIllegal(input xfer_t x);
        if (x.size > 3'd2) return 1'b1;
        if ((x.addr % (32'd1 << x.size)) != 32'd0) return 1'b1;
        if (x.addr >= 32'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelRead(input bit dut, input xfer_t x);
        int          n = 1 << x.size;
        int          a = int'(x.addr);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(modelMem[dut][a + i]) << (8 * i));
        if (x.sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic modelWrite(input bit dut, input xfer_t x);
        int n = 1 << x.size;
        int a = int'(x.addr);
        for (int i = 0; i < n; i++) modelMem[dut][a + i] = x.wdata[8*i +: 8];
    endtask

    task automatic modelClear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) modelMem[d][i] = 8'h00;
    endtask

    function automatic xfer_t randXfer();
        xfer_t x;
        x.wr    = 1'($urandom_range(0, 1));
        x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.addr  = 32'($urandom_range(0, 63));
        if (x.size <= 3'd2 && $urandom_range(0, 3) != 0) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
        if ($urandom_range(0, 11) == 0) x.addr = x.addr | (32'd1 << $urandom_range(AB, 31));
        x.sgn   = 1'($urandom_range(0, 1));
        x.wdata = $urandom;
        return x;
    endfunction

    task automatic driveAddr(input bit dut, input xfer_t x);
        useB = dut; hselA = !dut; hselB = dut; htrans = 2'b10;
        hwrite = x.wr; hsize = x.size; haddr = x.addr; isSigned = x.sgn;
    endtask

    task automatic driveIdle();
        hselA = 1'b0; hselB = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; haddr = 32'd0; isSigned = 1'b0;
    endtask

    // Called just after a rising edge; follows one data phase to its completing edge.
    task automatic waitPhase(input bit dut, input string tag, input int expLow, input bit expErr,
                             input logic [31:0] expData);
        int          lows = 0;
        bit          done = 1'b0;
        logic        rdy, resp;
        logic [31:0] rd;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            rdy  = dut ? hreadyB : hreadyA;
            resp = dut ? hrespB : hrespA;
            rd   = dut ? hrdataB : hrdataA;
            if (!rdy) begin
                lows++;
                checkOutput({tag, "/resp_wait"}, 32'(resp), 32'(expErr));
            end else begin
                checkOutput({tag, "/resp"}, 32'(resp), 32'(expErr));
                checkOutput({tag, "/rdata"}, rd, expData);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        checkOutput({tag, "/wait_cycles"}, 32'(lows), 32'(expLow));
    endtask

    task automatic runPhase(input bit dut, input xfer_t x, input string tag);
        bit          err = isIllegal(x);
        logic [31:0] expData = 32'd0;
        if (!err && !x.wr) expData = modelRead(dut, x);
        waitPhase(dut, tag, err ? 1 : (dut ? WS_B : WS_A), err, expData);
        if (!err && x.wr) modelWrite(dut, x);
    endtask

    task automatic applyStimulus(input bit dut, input xfer_t x, input string tag);
        driveAddr(dut, x);
        @(posedge clk); #1;
        driveIdle();
        hwdata = x.wdata;
        runPhase(dut, x, tag);
    endtask

    // Second transfer sits on the bus during the first's data phase.
    task automatic pipePair(input bit dut, input xfer_t a, input xfer_t b, input string tag);
        driveAddr(dut, a);
        @(posedge clk); #1;
        driveAddr(dut, b);
        hwdata = a.wdata;
        runPhase(dut, a, {tag, "/first"});
        driveIdle();
        hwdata = b.wdata;
        if (isIllegal(a)) begin
            @(negedge clk);
            checkOutput({tag, "/ign_ready"}, 32'(dut ? hreadyB : hreadyA), 32'd1);
            checkOutput({tag, "/ign_resp"}, 32'(dut ? hrespB : hrespA), 32'd0);
            checkOutput({tag, "/ign_rdata"}, dut ? hrdataB : hrdataA, 32'd0);
            @(posedge clk); #1;
        end else begin
            runPhase(dut, b, {tag, "/second"});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; useB = 1'b0; hwdata = 32'd0; hreadyIn_init: driveIdle();
        modelClear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset/readyA", 32'(hreadyA), 32'd1);
        checkOutput("reset/respA", 32'(hrespA), 32'd0);
        checkOutput("reset/rdataA", hrdataA, 32'd0);
        checkOutput("reset/readyB", 32'(hreadyB), 32'd1);
        checkOutput("reset/respB", 32'(hrespB), 32'd0);
        @(posedge clk); #1;

        applyStimulus(0, mk(0, 3'd2, 32'h00, 0, 0), "rd_reset_word");
        applyStimulus(0, mk(1, 3'd2, 32'h00, 0, 32'hDDCC_BBAA), "wr_word0");
        applyStimulus(0, mk(0, 3'd0, 32'h00, 1, 0), "rd_sbyte0");
        applyStimulus(0, mk(0, 3'd1, 32'h02, 0, 0), "rd_uhalf2");
        applyStimulus(0, mk(0, 3'd1, 32'h02, 1, 0), "rd_shalf2");
        applyStimulus(0, mk(0, 3'd0, 32'h01, 0, 0), "rd_ubyte1");
        applyStimulus(0, mk(1, 3'd2, 32'h10, 0, 32'h1234_5678), "wr_word10");
        applyStimulus(0, mk(0, 3'd2, 32'h10, 1, 0), "rd_word10");
        applyStimulus(0, mk(1, 3'd1, 32'h01, 0, 32'h0000_5555), "err_half_unaligned");
        applyStimulus(0, mk(0, 3'd3, 32'h00, 0, 0), "err_size3");
        applyStimulus(0, mk(0, 3'd2, 32'h00, 0, 0), "rd_after_err");
        applyStimulus(0, mk(0, 3'd2, 32'h100, 0, 0), "err_out_of_range");
        applyStimulus(0, mk(1, 3'd0, 32'h8000_0000, 0, 32'hFF), "err_high_addr");

        pipePair(1, mk(1, 3'd2, 32'h04, 0, 32'hCAFE_F00D), mk(0, 3'd2, 32'h04, 0, 0), "b2b_word4");
        pipePair(1, mk(1, 3'd1, 32'h06, 0, 32'h0000_8001), mk(0, 3'd1, 32'h06, 1, 0), "b2b_half6");
        pipePair(0, mk(1, 3'd0, 32'h13, 0, 32'h0000_0080), mk(0, 3'd0, 32'h13, 1, 0), "b2b_waitA");
        applyStimulus(1, mk(1, 3'd2, 32'h08, 0, 32'h0BAD_BEEF), "wr_word8");
        pipePair(1, mk(1, 3'd2, 32'h02, 0, 32'h1111_1111), mk(1, 3'd2, 32'h08, 0, 32'h2222_2222), "err2_ignore");
        applyStimulus(1, mk(0, 3'd2, 32'h08, 0, 0), "rd_word8");

        for (int i = 0; i < 40; i++) begin
            bit dut = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) pipePair(dut, randXfer(), randXfer(), "rand_pipe");
            else applyStimulus(dut, randXfer(), "rand_single");
        end

        applyStimulus(0, mk(1, 3'd2, 32'h20, 0, 32'h5A5A_A5A5), "wr_word20");
        driveAddr(0, mk(1, 3'd2, 32'h24, 0, 0));
        @(posedge clk); #1;
        driveIdle();
        hwdata = 32'h7777_7777;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        modelClear();
        @(negedge clk);
        checkOutput("midreset/ready", 32'(hreadyA), 32'd1);
        checkOutput("midreset/resp", 32'(hrespA), 32'd0);
        checkOutput("midreset/rdata", hrdataA, 32'd0);
        @(posedge clk); #1;
        applyStimulus(0, mk(0, 3'd2, 32'h24, 0, 0), "midreset_rd24");
        applyStimulus(0, mk(0, 3'd2, 32'h20, 0, 0), "midreset_rd20");
        applyStimulus(1, mk(0, 3'd2, 32'h04, 0, 0), "midreset_rdB4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
